// File: rtl/mips_pkg.sv
// Shared fetch-path definitions: fetch FSM state encoding, reset vector and jump-target helper.
// Used by fetch_ctrl (optional statistics enabled with FETCH_CTRL_STATS_EN) and npc_sel.
package mips_pkg;

    localparam logic [29:0] RESET_VECTOR = 30'h00100000;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_BOOT  = 2'd0;
    localparam fetch_state_t ST_FETCH = 2'd1;
    localparam fetch_state_t ST_HOLD  = 2'd2;
    localparam fetch_state_t ST_FLUSH = 2'd3;

    // Word-address form of a J-type target: the region bits are the top four bits of the PC.
    function automatic logic [29:0] jump_word(input logic [3:0] pc_region, input logic [25:0] index);
        return {pc_region, index};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch bus between the PC register, instruction memory, decode stage and fetch_ctrl.
// The slave modport is the fetch_ctrl view; master is the surrounding pipeline.
interface fetch_ctrl_if;

    logic [29:0] PC;
    logic [29:0] NPC;
    logic        IReq;
    logic        IAck;
    logic [31:0] Instr;
    logic [31:0] IR;
    logic        IValid;
    logic        Stall;
    logic        Jr;
    logic        Jump;
    logic        Br_taken;
    logic [29:0] Jr_target;
    logic [29:0] Br_target;
    logic [25:0] Jump_target;

    modport master (
        output PC, IAck, Instr, Stall, Jr, Jump, Br_taken, Jr_target, Br_target, Jump_target,
        input  NPC, IReq, IR, IValid
    );

    modport slave (
        input  PC, IAck, Instr, Stall, Jr, Jump, Br_taken, Jr_target, Br_target, Jump_target,
        output NPC, IReq, IR, IValid
    );

endinterface

// File: rtl/npc_sel.sv
// Redirect arbitration: Jr beats Jump beats Br_taken; Jump target is spliced onto the PC region.
module npc_sel
    import mips_pkg::*;
(
    input  logic [3:0]  pc_region,
    input  logic        jr,
    input  logic        jump,
    input  logic        br_taken,
    input  logic [29:0] jr_target,
    input  logic [25:0] jump_target,
    input  logic [29:0] br_target,
    output logic        redirect,
    output logic [29:0] target
);

    always_comb begin
        redirect = jr | jump | br_taken;
        target   = br_target;
        if (jr) begin
            target = jr_target;
        end else if (jump) begin
            target = jump_word(pc_region, jump_target);
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: BOOT/FETCH/HOLD/FLUSH sequencing of IR and next-PC selection.
// Define FETCH_CTRL_STATS_EN to add the Fetch_cnt / Flush_cnt statistics outputs.
module fetch_ctrl #(
    parameter logic [29:0] RESET_VECTOR = mips_pkg::RESET_VECTOR
) (
    input  logic        Clk,
    input  logic        Reset,
    fetch_ctrl_if.slave bus
`ifdef FETCH_CTRL_STATS_EN
    ,
    output logic [31:0] Fetch_cnt,
    output logic [31:0] Flush_cnt
`endif
);
    import mips_pkg::*;

    fetch_state_t state_q, state_d;
    logic [31:0]  ir_q, ir_d;
    logic         ivalid_q, ivalid_d;
    logic [29:0]  pending_q, pending_d;
    logic [29:0]  npc_d;
    logic         redirect;
    logic [29:0]  redirect_target;

    npc_sel u_npc_sel (
        .pc_region   (bus.PC[29:26]),
        .jr          (bus.Jr),
        .jump        (bus.Jump),
        .br_taken    (bus.Br_taken),
        .jr_target   (bus.Jr_target),
        .jump_target (bus.Jump_target),
        .br_target   (bus.Br_target),
        .redirect    (redirect),
        .target      (redirect_target)
    );

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        ivalid_d  = ivalid_q;
        pending_d = pending_q;
        npc_d     = bus.PC;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH: begin
                if (bus.IAck) begin
                    if (redirect) begin
                        npc_d = redirect_target;
                    end else begin
                        ir_d     = bus.Instr;
                        ivalid_d = 1'b1;
                        npc_d    = bus.PC + 30'd1;
                        state_d  = ST_HOLD;
                    end
                end else if (redirect) begin
                    // The outstanding request still has to complete; remember where to go afterwards.
                    pending_d = redirect_target;
                    state_d   = ST_FLUSH;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    ivalid_d = 1'b0;
                    npc_d    = redirect_target;
                    state_d  = ST_FETCH;
                end else if (!bus.Stall) begin
                    ivalid_d = 1'b0;
                    state_d  = ST_FETCH;
                end
            end
            ST_FLUSH: begin
                if (redirect) begin
                    pending_d = redirect_target;
                end
                if (bus.IAck) begin
                    npc_d   = redirect ? redirect_target : pending_q;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= ST_BOOT;
            ir_q      <= 32'd0;
            ivalid_q  <= 1'b0;
            pending_q <= RESET_VECTOR;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            ivalid_q  <= ivalid_d;
            pending_q <= pending_d;
        end
    end

    assign bus.NPC    = npc_d;
    assign bus.IReq   = (state_q == ST_FETCH) || (state_q == ST_FLUSH);
    assign bus.IR     = ir_q;
    assign bus.IValid = ivalid_q;

`ifdef FETCH_CTRL_STATS_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // A flush counts any fetched word that never reaches decode, including a valid IR killed in HOLD.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q == ST_FETCH && bus.IAck && !redirect) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if ((state_q == ST_FETCH && bus.IAck && redirect) ||
            (state_q == ST_FLUSH && bus.IAck) ||
            (state_q == ST_HOLD && redirect && ivalid_q)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fetch_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Fetch_cnt = fetch_cnt_q;
    assign Flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboarded bench for fetch_ctrl: directed fetch/stall/redirect/flush/reset vectors,
// with a monitor comparing every IR consumed by decode against the expected queue.
module tb_fetch_ctrl;
    import mips_pkg::*;

    typedef struct {
        logic [31:0] ir;
        logic [29:0] pc;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    fetch_ctrl_if bus ();

`ifdef FETCH_CTRL_STATS_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] flush_before;
`endif

    fetch_ctrl #(.RESET_VECTOR(RESET_VECTOR)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .bus       (bus)
`ifdef FETCH_CTRL_STATS_EN
        ,
        .Fetch_cnt (fetch_cnt),
        .Flush_cnt (flush_cnt)
`endif
    );

    int   check_count = 0;
    int   pass_count  = 0;
    int   fail_count  = 0;
    exp_t sb_q[$];

    logic        pc_force = 1'b0;
    logic        pc_force_req = 1'b0;
    logic [29:0] pc_force_val = 30'd0;
    logic [29:0] tgt_jr = 30'd0;
    logic [29:0] tgt_br = 30'd0;
    logic [25:0] tgt_jump = 26'd0;

    // Stand-in PC register: follows NPC, with a one-cycle load override for the wrap test.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            bus.PC <= RESET_VECTOR;
        end else if (pc_force) begin
            bus.PC <= pc_force_val;
        end else begin
            bus.PC <= bus.NPC;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic iack, input logic [31:0] instr, input logic stall,
                                 input logic jr, input logic jump, input logic br);
        @(negedge Clk);
        bus.IAck        = iack;
        bus.Instr       = instr;
        bus.Stall       = stall;
        bus.Jr          = jr;
        bus.Jump        = jump;
        bus.Br_taken    = br;
        bus.Jr_target   = tgt_jr;
        bus.Br_target   = tgt_br;
        bus.Jump_target = tgt_jump;
        pc_force        = pc_force_req;
        pc_force_req    = 1'b0;
        #1;
    endtask

    task automatic expectAccept(input logic [31:0] instr, input logic [29:0] next_pc);
        exp_t e;
        e.ir = instr;
        e.pc = next_pc;
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        forever begin
            @(negedge Clk);
            #2;
            if (Reset === 1'b1 && bus.IValid === 1'b1 && bus.Stall === 1'b0) begin
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected IR consumed", bus.IR, 32'hxxxxxxxx);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    checkOutput("consumed IR", bus.IR, e.ir);
                    checkOutput("PC at consume", 32'(bus.PC), 32'(e.pc));
                end
            end
        end
    end

    initial begin
        Reset           = 1'b0;
        bus.IAck        = 1'b0;
        bus.Instr       = 32'd0;
        bus.Stall       = 1'b0;
        bus.Jr          = 1'b0;
        bus.Jump        = 1'b0;
        bus.Br_taken    = 1'b0;
        bus.Jr_target   = 30'd0;
        bus.Br_target   = 30'd0;
        bus.Jump_target = 26'd0;

        repeat (2) @(negedge Clk);
        #1;
        checkOutput("reset IReq", 32'(bus.IReq), 32'd0);
        checkOutput("reset IValid", 32'(bus.IValid), 32'd0);
        checkOutput("reset IR", bus.IR, 32'd0);
        checkOutput("reset NPC", 32'(bus.NPC), 32'(RESET_VECTOR));

        // BOOT cycle: late IAck and a redirect must both be ignored
        tgt_jr = 30'h00300000;
        applyStimulus(1'b1, 32'hBAD00000, 1'b0, 1'b1, 1'b0, 1'b0);
        Reset = 1'b1;
        #1;
        checkOutput("boot IReq", 32'(bus.IReq), 32'd0);
        checkOutput("boot NPC", 32'(bus.NPC), 32'h00100000);

        applyStimulus(1'b1, 32'hA0000000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("fetch IReq", 32'(bus.IReq), 32'd1);
        checkOutput("accept0 NPC", 32'(bus.NPC), 32'h00100001);
        expectAccept(32'hA0000000, 30'h00100001);

        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("hold IValid", 32'(bus.IValid), 32'd1);
        checkOutput("hold NPC", 32'(bus.NPC), 32'h00100001);

        applyStimulus(1'b1, 32'hA0000001, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("accept1 NPC", 32'(bus.NPC), 32'h00100002);
        expectAccept(32'hA0000001, 30'h00100002);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("stall IValid", 32'(bus.IValid), 32'd1);
            checkOutput("stall IR", bus.IR, 32'hA0000001);
            checkOutput("stall NPC", 32'(bus.NPC), 32'h00100002);
        end
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("post-consume IValid", 32'(bus.IValid), 32'd0);
        checkOutput("post-consume IReq", 32'(bus.IReq), 32'd1);
        checkOutput("fetch wait NPC", 32'(bus.NPC), 32'h00100002);

        // This word gets killed in HOLD by a Jr+Br redirect, so it is not expected at decode
        applyStimulus(1'b1, 32'hA0000002, 1'b0, 1'b0, 1'b0, 1'b0);
        tgt_jr = 30'h00200000;
        tgt_br = 30'h00300000;
        applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("hold redirect NPC", 32'(bus.NPC), 32'h00200000);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("hold flush IValid", 32'(bus.IValid), 32'd0);
        checkOutput("after redirect NPC", 32'(bus.NPC), 32'h00200000);

        tgt_jr = 30'h24000010;
        applyStimulus(1'b1, 32'hDEAD0001, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("fetch+ack Jr NPC", 32'(bus.NPC), 32'h24000010);

        tgt_jump = 26'h0ABCDE;
        applyStimulus(1'b1, 32'hDEAD0002, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("jump priority NPC", 32'(bus.NPC), 32'h240ABCDE);

`ifdef FETCH_CTRL_STATS_EN
        flush_before = flush_cnt;
`endif
        tgt_br = 30'h00300040;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("branch no-ack NPC", 32'(bus.NPC), 32'h240ABCDE);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("flush IReq", 32'(bus.IReq), 32'd1);
            checkOutput("flush IValid", 32'(bus.IValid), 32'd0);
            checkOutput("flush NPC", 32'(bus.NPC), 32'h240ABCDE);
        end
        applyStimulus(1'b1, 32'hDEAD0003, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("flush ack NPC", 32'(bus.NPC), 32'h00300040);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("discarded IValid", 32'(bus.IValid), 32'd0);
        checkOutput("post-flush NPC", 32'(bus.NPC), 32'h00300040);
`ifdef FETCH_CTRL_STATS_EN
        checkOutput("Flush_cnt delta", flush_cnt - flush_before, 32'd1);
`endif

        // Pending target overwritten while in FLUSH
        tgt_jr = 30'h00400000;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tgt_br = 30'h00500000;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("overwrite hold NPC", 32'(bus.NPC), 32'h00300040);
        applyStimulus(1'b1, 32'hDEAD0004, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("overwritten pending NPC", 32'(bus.NPC), 32'h00500000);

        tgt_jr = 30'h00600000;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tgt_br = 30'h00700000;
        applyStimulus(1'b1, 32'hDEAD0005, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("flush same-cycle NPC", 32'(bus.NPC), 32'h00700000);

        pc_force_req = 1'b1;
        pc_force_val = 30'h3FFFFFFF;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hB0000000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("wrap NPC", 32'(bus.NPC), 32'h00000000);
        expectAccept(32'hB0000000, 30'h00000000);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in FLUSH with IAck arriving in the same cycle
        tgt_br = 30'h00800000;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pre-reset flush IReq", 32'(bus.IReq), 32'd1);
        applyStimulus(1'b1, 32'hDEAD0006, 1'b0, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        #1;
        checkOutput("mid-flush reset IReq", 32'(bus.IReq), 32'd0);
        checkOutput("mid-flush reset IValid", 32'(bus.IValid), 32'd0);
        checkOutput("mid-flush reset NPC", 32'(bus.NPC), 32'(RESET_VECTOR));
        applyStimulus(1'b1, 32'hDEAD0007, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("in-reset IReq", 32'(bus.IReq), 32'd0);
        applyStimulus(1'b1, 32'hDEAD0008, 1'b0, 1'b0, 1'b0, 1'b0);
        Reset = 1'b1;
        #1;
        checkOutput("re-boot IReq", 32'(bus.IReq), 32'd0);
        checkOutput("re-boot NPC", 32'(bus.NPC), 32'h00100000);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("re-fetch IReq", 32'(bus.IReq), 32'd1);
        checkOutput("re-fetch IValid", 32'(bus.IValid), 32'd0);
`ifdef FETCH_CTRL_STATS_EN
        checkOutput("Fetch_cnt after reset", fetch_cnt, 32'd0);
        checkOutput("Flush_cnt after reset", flush_cnt, 32'd0);
`endif
        applyStimulus(1'b1, 32'hC0000000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("re-accept NPC", 32'(bus.NPC), 32'h00100001);
        expectAccept(32'hC0000000, 30'h00100001);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef FETCH_CTRL_STATS_EN
        checkOutput("Fetch_cnt one accept", fetch_cnt, 32'd1);
`endif

        repeat (2) @(negedge Clk);
        #3;
        checkOutput("scoreboard drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
